// File: rtl/pwm_compare_deadtime.sv
// Three-phase compare PWM with shadowed compares and per-leg dead time.
// Ports: clk/rst (sync high), enable, new_cycle, triangle_count, cmp_a..c,
//   fault in; gate_hi/gate_lo[2:0] (bit0=A), load_ack, fault_latched out.
module pwm_compare_deadtime #(
  parameter int DEADTIME    = 40,
  parameter int CARRIER_MAX = 7999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        new_cycle,
  input  logic [15:0] triangle_count,
  input  logic [15:0] cmp_a,
  input  logic [15:0] cmp_b,
  input  logic [15:0] cmp_c,
  input  logic        fault,
  output logic [2:0]  gate_hi,
  output logic [2:0]  gate_lo,
  output logic        load_ack,
  output logic        fault_latched
);

  typedef enum logic [2:0] {
    ST_DEAD = 3'b001,
    ST_HIGH = 3'b010,
    ST_LOW  = 3'b100
  } leg_state_e;

  localparam logic [15:0] CMAX    = 16'(CARRIER_MAX);
  localparam logic [9:0]  DT_INIT = 10'(DEADTIME - 1);

  logic [15:0] cmp_in   [3];
  logic [15:0] active_q [3];
  logic [15:0] active_d [3];
  logic [2:0]  ref_q;
  logic [2:0]  ref_d;
  leg_state_e  state_q  [3];
  leg_state_e  state_d  [3];
  logic [9:0]  cnt_q    [3];
  logic [9:0]  cnt_d    [3];
  logic        load_ack_q;
  logic        load_ack_d;
  logic        fault_latched_q;
  logic        fault_latched_d;
  logic        run;
  logic        do_load;

  assign cmp_in[0] = cmp_a;
  assign cmp_in[1] = cmp_b;
  assign cmp_in[2] = cmp_c;

  always_comb begin
    // A fault on this edge already blocks conduction and loads.
    run             = enable & ~fault & ~fault_latched_q;
    do_load         = run & new_cycle;
    fault_latched_d = fault_latched_q | fault;
    load_ack_d      = do_load;
    ref_d           = '0;
    for (int i = 0; i < 3; i++) begin
      active_d[i] = active_q[i];
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      if (do_load) begin
        active_d[i] = (cmp_in[i] > CMAX) ? CMAX : cmp_in[i];
      end
      ref_d[i] = triangle_count < active_q[i];
      if (!run) begin
        state_d[i] = ST_DEAD;
        cnt_d[i]   = DT_INIT;
      end else begin
        case (state_q[i])
          ST_HIGH: begin
            if (!ref_q[i]) begin
              state_d[i] = ST_DEAD;
              cnt_d[i]   = DT_INIT;
            end
          end
          ST_LOW: begin
            if (ref_q[i]) begin
              state_d[i] = ST_DEAD;
              cnt_d[i]   = DT_INIT;
            end
          end
          ST_DEAD: begin
            // Dead time always runs to completion, then follows ref.
            if (cnt_q[i] == '0) begin
              state_d[i] = ref_q[i] ? ST_HIGH : ST_LOW;
            end else begin
              cnt_d[i] = cnt_q[i] - 10'd1;
            end
          end
          default: begin
            state_d[i] = ST_DEAD;
            cnt_d[i]   = DT_INIT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q           <= '0;
      load_ack_q      <= 1'b0;
      fault_latched_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        active_q[i] <= '0;
        state_q[i]  <= ST_DEAD;
        cnt_q[i]    <= DT_INIT;
      end
    end else begin
      ref_q           <= ref_d;
      load_ack_q      <= load_ack_d;
      fault_latched_q <= fault_latched_d;
      for (int i = 0; i < 3; i++) begin
        active_q[i] <= active_d[i];
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  // Gates come straight from the one-hot state flops.
  assign gate_hi = {state_q[2][1], state_q[1][1], state_q[0][1]};
  assign gate_lo = {state_q[2][2], state_q[1][2], state_q[0][2]};
  assign load_ack      = load_ack_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Bench for pwm_compare_deadtime: table rows plus ramp/fault sequences,
// expected values queued at drive time and checked when due.
module tb_pwm_compare_deadtime;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        new_cycle;
  logic [15:0] tcount;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic [15:0] cmp_c;
  logic        fault;
  logic [2:0]  gate_hi;
  logic [2:0]  gate_lo;
  logic        load_ack;
  logic        fault_latched;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pwm_compare_deadtime #(
    .DEADTIME   (40),
    .CARRIER_MAX(7999)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .new_cycle     (new_cycle),
    .triangle_count(tcount),
    .cmp_a         (cmp_a),
    .cmp_b         (cmp_b),
    .cmp_c         (cmp_c),
    .fault         (fault),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .load_ack      (load_ack),
    .fault_latched (fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rst;
    logic        en;
    logic        nc;
    logic [15:0] tc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        flt;
    int          hold;
    logic [2:0]  hi;
    logic [2:0]  lo;
    logic        ack;
    logic        fl;
    string       name;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] hi;
    logic [2:0] lo;
    logic       ack;
    logic       fl;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[$];

  function automatic vec_t mkv(
    logic r, logic en, logic nc, int tc,
    int a, int b, int c, logic f, int hold,
    logic [2:0] hi, logic [2:0] lo,
    logic ack, logic fl, string name);
    vec_t v;
    v.rst = r; v.en = en; v.nc = nc;
    v.tc = 16'(tc); v.a = 16'(a);
    v.b = 16'(b); v.c = 16'(c);
    v.flt = f; v.hold = hold;
    v.hi = hi; v.lo = lo;
    v.ack = ack; v.fl = fl; v.name = name;
    return v;
  endfunction

  task automatic sb_push(
    int off, logic [2:0] hi, logic [2:0] lo,
    logic ack, logic fl, string name);
    exp_t e;
    e.cyc = cyc + off; e.hi = hi; e.lo = lo;
    e.ack = ack; e.fl = fl; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      total++;
      if ((gate_hi & gate_lo) != 3'b000) begin
        bad++;
        $display("FAIL overlap cyc=%0d hi=%b lo=%b need disjoint",
                 cyc, gate_hi, gate_lo);
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (mon_e.cyc < cyc ||
          {gate_hi, gate_lo, load_ack, fault_latched} !==
          {mon_e.hi, mon_e.lo, mon_e.ack, mon_e.fl}) begin
        bad++;
        $display("FAIL %s cyc=%0d got hi=%b lo=%b ack=%b fl=%b need hi=%b lo=%b ack=%b fl=%b",
                 mon_e.name, cyc, gate_hi, gate_lo, load_ack,
                 fault_latched, mon_e.hi, mon_e.lo, mon_e.ack, mon_e.fl);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; new_cycle = 1'b0;
    tcount = '0; cmp_a = '0; cmp_b = '0; cmp_c = '0;
    fault = 1'b0;
    step();

    //               r  en nc tc    a     b     c      f  hold hi    lo   ack fl
    tbl.push_back(mkv(1, 0, 0, 0,    0,    0,    0,    0, 2,  3'b000, 3'b000, 0, 0, "reset"));
    tbl.push_back(mkv(0, 1, 1, 0,    2000, 1000, 0,    0, 1,  3'b000, 3'b000, 1, 0, "load_ack"));
    tbl.push_back(mkv(0, 1, 0, 0,    2000, 1000, 0,    0, 1,  3'b000, 3'b000, 0, 0, "ack_pulse"));
    tbl.push_back(mkv(0, 1, 0, 0,    2000, 1000, 0,    0, 37, 3'b000, 3'b000, 0, 0, "init_dead"));
    tbl.push_back(mkv(0, 1, 0, 0,    2000, 1000, 0,    0, 1,  3'b011, 3'b100, 0, 0, "init_conduct"));
    tbl.push_back(mkv(0, 1, 0, 1500, 2000, 1000, 0,    0, 3,  3'b001, 3'b100, 0, 0, "b_off"));
    tbl.push_back(mkv(0, 1, 0, 1500, 2000, 1000, 0,    0, 38, 3'b001, 3'b100, 0, 0, "b_dead"));
    tbl.push_back(mkv(0, 1, 0, 1500, 2000, 1000, 0,    0, 1,  3'b001, 3'b110, 0, 0, "b_low"));
    tbl.push_back(mkv(0, 1, 0, 1500, 2000, 5000, 0,    0, 5,  3'b001, 3'b110, 0, 0, "shadow_hold"));
    tbl.push_back(mkv(0, 1, 1, 1500, 2000, 5000, 0,    0, 1,  3'b001, 3'b110, 1, 0, "shadow_load"));
    tbl.push_back(mkv(0, 1, 0, 1500, 2000, 5000, 0,    0, 2,  3'b001, 3'b100, 0, 0, "shadow_dead"));
    tbl.push_back(mkv(0, 1, 0, 1500, 2000, 5000, 0,    0, 40, 3'b011, 3'b100, 0, 0, "shadow_high"));
    tbl.push_back(mkv(0, 1, 1, 1500, 2000, 5000, 65535,0, 1,  3'b011, 3'b100, 1, 0, "clamp_load"));
    tbl.push_back(mkv(0, 1, 0, 1500, 2000, 5000, 65535,0, 42, 3'b111, 3'b000, 0, 0, "clamp_high"));
    tbl.push_back(mkv(0, 1, 0, 7999, 2000, 5000, 65535,0, 2,  3'b000, 3'b000, 0, 0, "peak_dip"));
    tbl.push_back(mkv(0, 1, 0, 7998, 2000, 5000, 65535,0, 42, 3'b100, 3'b011, 0, 0, "peak_recover"));
    tbl.push_back(mkv(0, 1, 1, 7998, 2000, 5000, 0,    0, 1,  3'b100, 3'b011, 1, 0, "zero_load"));
    tbl.push_back(mkv(0, 1, 0, 0,    2000, 5000, 0,    0, 42, 3'b011, 3'b100, 0, 0, "cmp_zero"));
    tbl.push_back(mkv(0, 0, 0, 0,    2000, 5000, 0,    0, 1,  3'b000, 3'b000, 0, 0, "disable"));
    tbl.push_back(mkv(0, 0, 1, 500,  100,  5000, 0,    0, 3,  3'b000, 3'b000, 0, 0, "dis_no_load"));
    tbl.push_back(mkv(0, 1, 0, 500,  100,  5000, 0,    0, 39, 3'b000, 3'b000, 0, 0, "reen_dead"));
    tbl.push_back(mkv(0, 1, 0, 500,  100,  5000, 0,    0, 1,  3'b011, 3'b100, 0, 0, "reen_conduct"));
    tbl.push_back(mkv(0, 1, 0, 500,  2000, 5000, 0,    1, 1,  3'b000, 3'b000, 0, 1, "fault_trip"));
    tbl.push_back(mkv(0, 0, 0, 500,  2000, 5000, 0,    0, 2,  3'b000, 3'b000, 0, 1, "fault_dis"));
    tbl.push_back(mkv(0, 1, 1, 500,  2000, 5000, 0,    0, 50, 3'b000, 3'b000, 0, 1, "fault_sticky"));
    tbl.push_back(mkv(1, 1, 0, 500,  2000, 5000, 0,    0, 1,  3'b000, 3'b000, 0, 0, "fault_rst"));
    tbl.push_back(mkv(0, 1, 1, 500,  2000, 5000, 0,    0, 1,  3'b000, 3'b000, 1, 0, "rst_load"));
    tbl.push_back(mkv(0, 1, 0, 500,  2000, 5000, 0,    0, 38, 3'b000, 3'b000, 0, 0, "rst_dead"));
    tbl.push_back(mkv(0, 1, 0, 500,  2000, 5000, 0,    0, 1,  3'b011, 3'b100, 0, 0, "rst_conduct"));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; enable = tbl[i].en;
      new_cycle = tbl[i].nc; tcount = tbl[i].tc;
      cmp_a = tbl[i].a; cmp_b = tbl[i].b;
      cmp_c = tbl[i].c; fault = tbl[i].flt;
      sb_push(tbl[i].hold, tbl[i].hi, tbl[i].lo,
              tbl[i].ack, tbl[i].fl, tbl[i].name);
      repeat (tbl[i].hold) step();
    end

    // Ramp phase A through 2000: off 2 cycles later, lo on 40 after.
    for (int v = 1990; v <= 2060; v++) begin
      tcount = 16'(v);
      if (v == 2000) begin
        sb_push(1,  3'b011, 3'b100, 0, 0, "ramp_pre");
        sb_push(2,  3'b010, 3'b100, 0, 0, "ramp_off");
        sb_push(41, 3'b010, 3'b100, 0, 0, "ramp_dead_end");
        sb_push(42, 3'b010, 3'b101, 0, 0, "ramp_lo_on");
      end
      step();
    end

    // One-cycle fault while conducting, then enable toggles and rst.
    fault = 1'b1;
    sb_push(1, 3'b000, 3'b000, 0, 1, "pulse_trip");
    step();
    fault = 1'b0; enable = 1'b0;
    sb_push(1, 3'b000, 3'b000, 0, 1, "pulse_hold");
    step();
    enable = 1'b1;
    sb_push(3, 3'b000, 3'b000, 0, 1, "pulse_reen");
    repeat (3) step();
    rst = 1'b1;
    sb_push(1, 3'b000, 3'b000, 0, 0, "pulse_rst");
    step();
    rst = 1'b0;

    for (int k = 0; k < 100 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d need 0", sb.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_compare_deadtime.md
PWM_COMPARE_DEADTIME -- requirements
Module: pwm_compare_deadtime

Interface
REQ-001 Parameter DEADTIME, default 40, dead time in clk cycles (1 us at 40 MHz); legal range 1..1023.
REQ-002 Parameter CARRIER_MAX, default 7999, carrier peak count; compare values are clamped to this.
REQ-003 clk  input  1  sole clock (40 MHz); all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  modulator run; low forces all gates off.
REQ-006 new_cycle  input  1  carrier-valley pulse; shadow-to-active load strobe.
REQ-007 triangle_count  input  16  carrier count, 0..CARRIER_MAX, up/down.
REQ-008 cmp_a, cmp_b, cmp_c  input  16 each  shadow duty compare values, phases A/B/C.
REQ-009 fault  input  1  hardware trip request, level-sensitive.
REQ-010 gate_hi  output  3  high-side gate commands, bit 0 = A, bit 1 = B, bit 2 = C.
REQ-011 gate_lo  output  3  low-side gate commands, same bit order.
REQ-012 load_ack  output  1  one-cycle pulse confirming an active-compare load.
REQ-013 fault_latched  output  1  sticky trip status.

Function
REQ-014 On an edge with enable=1 and new_cycle=1, each active compare SHALL load min(cmp_x, CARRIER_MAX); otherwise it holds.
REQ-015 load_ack SHALL be 1 for exactly the cycle after the load edge; it is 0 otherwise.
REQ-016 A new active value SHALL first affect the comparison in the cycle after it is loaded; cmp_x changes at any other time SHALL have no effect.
REQ-017 Per phase, the registered reference ref_x SHALL be (triangle_count < active_x); its latency is 1 cycle.
REQ-018 Each leg SHALL be a one-hot FSM with states DEAD, HIGH and LOW, plus a 10-bit dead counter.
REQ-019 HIGH SHALL drive gate_hi=1 and gate_lo=0; LOW SHALL drive gate_hi=0 and gate_lo=1; DEAD SHALL drive both 0.
  - Gates are driven directly from state flops.
  - gate_hi and gate_lo of one leg SHALL never both be 1.
REQ-020 HIGH SHALL go to DEAD when ref_x=0; LOW SHALL go to DEAD when ref_x=1; entering DEAD loads the counter with DEADTIME-1.
REQ-021 DEAD SHALL decrement each cycle; at count 0 it goes to HIGH if ref_x=1, else LOW.
  - The leg is in DEAD for exactly DEADTIME cycles.
  - If ref_x reverts during DEAD, the full dead time still completes.
REQ-022 Edge latency: from a triangle_count crossing to gates off is 2 cycles; the opposite gate turns on DEADTIME cycles later.
REQ-023 Pulse widths SHALL NOT be filtered: a ref_x pulse shorter than DEADTIME yields DEAD only, with no gate-on.
REQ-024 active_x=0 SHALL give a permanent LOW after the initial dead time.
  - active_x=CARRIER_MAX gives HIGH, except at carrier peaks where triangle_count=CARRIER_MAX.
REQ-025 When enable=0, all legs SHALL be forced to DEAD with counter DEADTIME-1, and all gates are 0.
  - Active compares hold their values.
  - No loads occur and load_ack=0.
  - On re-enable, every leg serves a full dead time before conducting.
REQ-026 When fault=1 at an edge, fault_latched SHALL set to 1 and all legs are forced to DEAD on that edge.
  - Gates stay 0 while fault_latched=1, regardless of enable.
  - Only rst clears fault_latched.
REQ-027 Priority SHALL be: rst > fault/fault_latched > enable=0 > normal operation.

Reset
REQ-028 On rst=1 at an edge:
  - gate_hi=0, gate_lo=0, load_ack=0, fault_latched=0.
  - active compares are 0 and ref_x is 0.
  - all legs are in DEAD with counter DEADTIME-1.
REQ-029 Reset mid-operation (including mid dead time or while tripped) SHALL take effect on the same edge with no partial state retained.

Verification
REQ-030 Load: rst, enable=1, cmp_a=2000, new_cycle pulse -> load_ack=1 next cycle; phase A is HIGH while triangle_count<2000 and LOW otherwise.
REQ-031 Dead time: DEADTIME=40, ramp triangle_count through 2000 -> gate_hi[0] falls 2 cycles after the crossing; gate_lo[0] rises exactly 40 cycles later; both gates are never 1 together.
REQ-032 Shadow: change cmp_b from 1000 to 5000 mid-period with no new_cycle -> no change in phase B; after the next new_cycle the 5000 duty applies.
REQ-033 Clamp/extremes: cmp_c=65535 -> active=7999, with dead-only dips at the carrier peak; cmp_c=0 -> gate_lo[2] is continuously 1.
REQ-034 Fault: pulse fault for 1 cycle while conducting -> all gates 0 on the next edge; fault_latched=1 persists after enable toggles until rst.
REQ-035 Enable/reset: drop enable mid-HIGH -> gates 0 next edge; re-enable -> 40 cycles of both gates 0 before any gate-on; repeat with rst -> same.
